// File: rtl/seizure_alarm_pkg.sv
// Shared types and constants for the seizure alarm controller.
// The HOLDOFF state exists only when SEIZURE_ALARM_HOLDOFF_EN is defined.
package seizure_alarm_pkg;

  localparam int ALARM_CNT_W = 16;
  localparam logic [ALARM_CNT_W-1:0] ALARM_CNT_MAX = 16'hFFFF;

`ifdef SEIZURE_ALARM_HOLDOFF_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } state_t;
`endif

  function automatic logic [ALARM_CNT_W-1:0] sat_inc(input logic [ALARM_CNT_W-1:0] v);
    return (v == ALARM_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/seizure_win_counter.sv
// Sliding window of the last WIN_LEN decisions with a running count of ones
// and a saturating fill counter.
module seizure_win_counter #(
  parameter int WIN_LEN = 16,
  localparam int CNT_W = $clog2(WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift,
  input  logic             din,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             full
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(WIN_LEN);

  logic [WIN_LEN-1:0] win, win_next;
  logic [CNT_W-1:0]   fill, fill_next;
  logic               oldest;

  // Until the window has filled, the slot being evicted never held a real sample.
  assign oldest = (fill == FILL_MAX) ? win[WIN_LEN-1] : 1'b0;

  always_comb begin
    win_next   = win;
    fill_next  = fill;
    count_next = count;
    if (clear) begin
      win_next   = '0;
      fill_next  = '0;
      count_next = '0;
    end else if (shift) begin
      win_next   = {win[WIN_LEN-2:0], din};
      fill_next  = (fill == FILL_MAX) ? fill : fill + CNT_W'(1);
      count_next = count + CNT_W'(din) - CNT_W'(oldest);
    end
  end

  // full describes the window as it stands after the current edge's update.
  assign full = (fill_next == FILL_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win   <= '0;
      fill  <= '0;
      count <= '0;
    end else begin
      win   <= win_next;
      fill  <= fill_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/seizure_alarm_ctrl.sv
// Alarm controller: raises a latched alarm when enough recent predictions are positive.
// Optional post-clear holdoff is built when SEIZURE_ALARM_HOLDOFF_EN is defined.
module seizure_alarm_ctrl
  import seizure_alarm_pkg::*;
#(
  parameter int WIN_LEN     = 16,
  parameter int THRESH      = 12,
  parameter int HOLDOFF_LEN = 32,
  localparam int CNT_W = $clog2(WIN_LEN + 1)
) (
  input  logic                   apb_clk,
  input  logic                   reset_n,
  input  logic                   pred_valid,
  input  logic                   seizure_prediction,
  input  logic                   alarm_enable,
  input  logic                   alarm_clear,
  output logic                   alarm,
  output logic                   irq,
  output logic [CNT_W-1:0]       hit_count,
  output logic [ALARM_CNT_W-1:0] alarm_count
);

  if (WIN_LEN < 2 || WIN_LEN > 64) begin : g_bad_win
    $error("WIN_LEN must be in 2..64");
  end
  if (THRESH < 1 || THRESH > WIN_LEN) begin : g_bad_thresh
    $error("THRESH must be in 1..WIN_LEN");
  end
  if (HOLDOFF_LEN < 1 || HOLDOFF_LEN > 255) begin : g_bad_holdoff
    $error("HOLDOFF_LEN must be in 1..255");
  end

  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  state_t                 state, state_next;
  logic                   win_shift, win_clear, win_full, enter_alarm;
  logic [CNT_W-1:0]       count_next;
  logic [ALARM_CNT_W-1:0] alarm_cnt_q;

`ifdef SEIZURE_ALARM_HOLDOFF_EN
  localparam logic [7:0] HO_LAST = 8'(HOLDOFF_LEN - 1);
  logic [7:0] ho_cnt, ho_next;
`endif

  seizure_win_counter #(.WIN_LEN(WIN_LEN)) u_win (
    .clk        (apb_clk),
    .reset_n    (reset_n),
    .shift      (win_shift),
    .din        (seizure_prediction),
    .clear      (win_clear),
    .count      (hit_count),
    .count_next (count_next),
    .full       (win_full)
  );

  always_comb begin
    state_next  = state;
    win_shift   = 1'b0;
    win_clear   = 1'b0;
    enter_alarm = 1'b0;
`ifdef SEIZURE_ALARM_HOLDOFF_EN
    ho_next     = ho_cnt;
`endif
    // Disable outranks clear and samples arriving in the same cycle.
    if (!alarm_enable) begin
      state_next = IDLE;
      win_clear  = 1'b1;
`ifdef SEIZURE_ALARM_HOLDOFF_EN
      ho_next    = '0;
`endif
    end else begin
      case (state)
        IDLE: state_next = MONITOR;
        MONITOR: begin
          win_shift = pred_valid;
          if (pred_valid && win_full && count_next >= THRESH_V) begin
            state_next  = ALARM;
            enter_alarm = 1'b1;
          end
        end
        ALARM: begin
          if (alarm_clear) begin
            win_clear = 1'b1;
`ifdef SEIZURE_ALARM_HOLDOFF_EN
            state_next = HOLDOFF;
`else
            state_next = MONITOR;
`endif
          end else begin
            win_shift = pred_valid;
          end
        end
`ifdef SEIZURE_ALARM_HOLDOFF_EN
        HOLDOFF: begin
          win_shift = pred_valid;
          if (pred_valid) begin
            if (ho_cnt == HO_LAST) begin
              state_next = MONITOR;
              ho_next    = '0;
            end else begin
              ho_next = ho_cnt + 8'd1;
            end
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge apb_clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      irq         <= 1'b0;
      alarm_cnt_q <= '0;
`ifdef SEIZURE_ALARM_HOLDOFF_EN
      ho_cnt      <= '0;
`endif
    end else begin
      state <= state_next;
      irq   <= enter_alarm;
      if (enter_alarm) begin
        alarm_cnt_q <= sat_inc(alarm_cnt_q);
      end
`ifdef SEIZURE_ALARM_HOLDOFF_EN
      ho_cnt <= ho_next;
`endif
    end
  end

  assign alarm       = (state == ALARM);
  assign alarm_count = alarm_cnt_q;

endmodule
